delay_line_arbiter: RTL and testbench
=====================================

Name: delay_line_arbiter

Overview:
- Shares one `delay_line` instance (N-bit data, DELAY ce-qualified stages) between NREQ requesters.
- Per cycle: round-robin grant, drive the line's ce/idata, and carry a valid+requester-ID tag alongside the data.
- Each sample exits DELAY enabled cycles later on rsp_data, marked with the ID of the requester that issued it.
- Sits between requester clients and the `delay_line`; the `delay_line` is instantiated outside this block.

Parameters:
- N, 4, data width; must match the `delay_line`'s N.
- DELAY, 1, stage count of the `delay_line`; ≥1.
- NREQ, 2, number of requesters; 2..8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  leave IDLE and start arbitrating.
- hold  in  1  freeze: dl_ce=0, no grants, tag pipe frozen.
- flush  in  1  stop granting and drain in-flight samples.
- req_valid  in  NREQ  per-requester sample valid.
- req_data  in  NREQ*N  packed samples; requester k at [k*N +: N].
- req_ready  out  NREQ  one-hot grant; handshake = valid & ready.
- dl_ce  out  1  to `delay_line` ce.
- dl_idata  out  N  to `delay_line` idata.
- dl_odata  in  N  from `delay_line` odata.
- rsp_valid  out  1  rsp_data/rsp_id valid this cycle.
- rsp_id  out  $clog2(NREQ) (min 1)  originating requester.
- rsp_data  out  N  equals dl_odata.
- flush_done  out  1  one-cycle pulse when drain completes.

Behaviour:
- `delay_line` contract: on each clk edge with ce=1, stage k+1 takes stage k. dl_odata = idata presented DELAY ce-edges earlier.
- Reset (rst_n=0 at posedge):
  - state=IDLE, rr pointer=0, tag pipe cleared.
  - Outputs: req_ready=0, dl_ce=0, dl_idata=0, rsp_valid=0, rsp_id=0, flush_done=0.
- States:
  - IDLE: dl_ce=0, no grants. en=1 → RUN.
  - RUN:
    - flush=1 → DRAIN. flush has priority over grant in that cycle: no grant is issued.
    - en=0 and tag pipe empty → IDLE. en=0 and tag pipe non-empty → DRAIN.
  - DRAIN: dl_ce=1 unless hold, no grants. Tag pipe empty → flush_done pulse, → IDLE.
- dl_ce = (state≠IDLE) & ~hold. Combinational from registered state and hold.
- Grant (RUN, dl_ce=1):
  - Combinational round-robin over req_valid, starting at rr pointer.
  - req_ready is one-hot to the winner; all zero if no requester is valid.
  - dl_idata = winner's data; dl_idata=0 with no winner (bubble).
  - Grant in cycle t → rr pointer = winner+1 mod NREQ at t+1. Pointer unchanged on idle cycles.
- Tag pipe: DELAY entries of {valid, id}. Advances only when dl_ce=1. Entry 0 loads {granted, winner}.
- Response:
  - rsp_valid = last tag valid & dl_ce_q, where dl_ce_q is dl_ce registered. This suppresses duplicate outputs while held.
  - rsp_id = last tag id. rsp_data = dl_odata.
  - Latency: a grant in cycle t with no hold appears as rsp_valid in cycle t+DELAY.
  - Each hold cycle in between adds one cycle.
- Boundaries:
  - hold in the same cycle as valid: no grant; requester keeps valid.
  - flush while tag pipe is empty: → DRAIN, flush_done in the next cycle.
  - hold during DRAIN extends the drain.
  - rst_n low mid-operation drops in-flight samples. No rsp_valid after reset.
  - Single active requester: granted every enabled cycle.
  - All NREQ active: strict rotation, no requester starves for more than NREQ-1 grants.

Optional Feature:
- DL_ARB_STATS_EN defined:
  - Per-requester 16-bit grant counters, saturating at 0xFFFF.
  - Exposed on output stat_grants [NREQ*16].
  - Cleared by reset.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package dl_arb_pkg: state enum (IDLE=0, RUN=1, DRAIN=2), tag struct {valid, id}, ID-width function, stat counter width 16.
- Sub-module rr_arbiter: parameter NREQ; inputs valid, enable, pointer; outputs one-hot grant and index. Purely combinational.
- Pointer register stays in the top module.

Test Plan:
1. Reset with rst_n=0 for 3 cycles, all req_valid=1 → req_ready=0, dl_ce=0, rsp_valid=0. en=1 → first grant to requester 0 on the next cycle.
2. NREQ=2, DELAY=3, both valid, data 0xA and 0x5 → grants alternate 0,1,0,1. rsp_valid from cycle t+3 with rsp_id 0,1,0,1 and rsp_data A,5,A,5.
3. Single requester 1 sends 0..7 back-to-back → eight consecutive rsp_valid, data 0..7, rsp_id=1, zero bubbles.
4. hold=1 for 2 cycles while 2 samples are in flight (DELAY=3) → dl_ce=0, rsp_valid=0 during hold. Responses delayed by 2 cycles, none lost or duplicated.
5. flush with 2 in flight, DELAY=3 → no new grants. Both responses emerge, flush_done pulses once, state returns to IDLE.
6. rst_n low for 1 cycle mid-stream → no rsp_valid afterward until new grants are issued after en. With DL_ARB_STATS_EN, counters equal exact grant counts before reset and 0 after.

Source files
------------

// File: rtl/dl_arb_pkg.sv
// Shared types and helpers for the delay-line arbiter: FSM states, the
// {valid, id} tag carried alongside each sample, and the stat counter width.
package dl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Widest requester ID (NREQ <= 8); narrower configs zero-extend into it.
  localparam int TAG_IDW = 3;
  localparam int STAT_W  = 16;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first valid requester at or after
// pointer_i wins. No state; the pointer register lives in the caller.
module rr_arbiter
  import dl_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic            enable_i,
  input  logic [IDW-1:0]  pointer_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  index_o
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    grant_o = '0;
    index_o = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(pointer_i) + i) % NREQ);
      if (enable_i && !found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        index_o       = cand;
      end
    end
  end

endmodule

// File: rtl/delay_line_arbiter.sv
// Shares one external ce-qualified delay line between NREQ requesters and
// tags each sample with its requester ID. Optional grant counters: DL_ARB_STATS_EN.
//
// state | meaning
// IDLE  | line stopped, no grants
// RUN   | round-robin grants, line advancing unless held
// DRAIN | no grants, line advancing until the tag pipe is empty
module delay_line_arbiter
  import dl_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int DELAY = 1,
  parameter int NREQ  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                hold,
  input  logic                flush,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*N-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                dl_ce,
  output logic [N-1:0]        dl_idata,
  input  logic [N-1:0]        dl_odata,
  output logic                rsp_valid,
  output logic [id_width(NREQ)-1:0] rsp_id,
  output logic [N-1:0]        rsp_data,
  output logic                flush_done
`ifdef DL_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0] stat_grants
`endif
);

  localparam int IDW = id_width(NREQ);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  tag_t            tag_q [DELAY];
  logic            dl_ce_q;

  logic            grant_en;
  logic            granted;
  logic            pipe_busy;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx;

  // No new samples once en drops, so nothing is left stranded in IDLE.
  assign grant_en = (state_q == RUN) && !hold && en && !flush;
  assign granted  = |grant;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .valid_i   (req_valid),
    .enable_i  (grant_en),
    .pointer_i (ptr_q),
    .grant_o   (grant),
    .index_o   (win_idx)
  );

  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k < DELAY; k++) begin
      pipe_busy = pipe_busy | tag_q[k].valid;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN: begin
        if (flush)         state_d = DRAIN;
        else if (!en)      state_d = pipe_busy ? DRAIN : IDLE;
      end
      DRAIN:   if (!pipe_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dl_ce      = (state_q != IDLE) && !hold;
    req_ready  = grant;
    dl_idata   = granted ? req_data[win_idx*N +: N] : '0;
    flush_done = (state_q == DRAIN) && !pipe_busy;
    ptr_d      = ptr_q;
    if (granted) begin
      ptr_d = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dl_ce_q <= 1'b0;
      for (int k = 0; k < DELAY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dl_ce_q <= dl_ce;
      if (dl_ce) begin
        tag_q[0].valid <= granted;
        tag_q[0].id    <= TAG_IDW'(win_idx);
        for (int k = 1; k < DELAY; k++) begin
          tag_q[k] <= tag_q[k-1];
        end
      end
    end
  end

  // Gating with the registered ce hides the last stage while it sits frozen.
  assign rsp_valid = tag_q[DELAY-1].valid && dl_ce_q;
  assign rsp_id    = tag_q[DELAY-1].id[IDW-1:0];
  assign rsp_data  = dl_odata;

`ifdef DL_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NREQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (grant[k] && (cnt_q[k] != '1)) begin
          cnt_q[k] <= cnt_q[k] + STAT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_grants[g*STAT_W +: STAT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Bench for delay_line_arbiter (NREQ=2, DELAY=3, N=4) with a behavioural
// delay line, a directed vector table, corner sequences and random traffic.
module tb_delay_line_arbiter;

  localparam int N     = 4;
  localparam int DELAY = 3;
  localparam int NREQ  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0, hold = 1'b0, flush = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*N-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              dl_ce;
  logic [N-1:0]      dl_idata, dl_odata, rsp_data;
  logic              rsp_valid;
  logic [0:0]        rsp_id;
  logic              flush_done;
`ifdef DL_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_grants;
`endif

  always #5 clk = ~clk;

  delay_line_arbiter #(.N(N), .DELAY(DELAY), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .hold       (hold),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .dl_ce      (dl_ce),
    .dl_idata   (dl_idata),
    .dl_odata   (dl_odata),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .flush_done (flush_done)
`ifdef DL_ARB_STATS_EN
    ,
    .stat_grants(stat_grants)
`endif
  );

  // External delay line: dl_odata is the idata presented DELAY ce-edges ago.
  logic [N-1:0] dl_stage [DELAY];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DELAY; k++) dl_stage[k] <= '0;
    end else if (dl_ce === 1'b1) begin
      dl_stage[0] <= dl_idata;
      for (int k = 1; k < DELAY; k++) dl_stage[k] <= dl_stage[k-1];
    end
  end
  assign dl_odata = dl_stage[DELAY-1];

  int checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: each issued sample is a record counting the ce edges
  // still needed to reach the line's last stage.
  typedef struct {int id; int data; int left;} rec_t;
  rec_t recs[$];
  int   m_state = 0;   // 0 idle, 1 run, 2 drain
  int   m_ptr = 0;
  bit   m_prev_ce = 0;
  int   m_cnt [NREQ];

  typedef struct {
    bit r, e, h, f;
    logic [1:0] v;
    logic [1:0] rdy;
    bit ce;
    logic [3:0] idat;
    bit rv;
    bit id;
    logic [3:0] rd;
    bit fd;
  } vec_t;

  vec_t tab [13];
  vec_t none_v;

  bit         obs_rv, obs_fd;
  logic [3:0] obs_rd;

  // mode: 0 check against model, 1 check against table row, 2 no check
  task automatic step(input int mode, input bit r, e, h, f,
                      input logic [1:0] v, input logic [7:0] d, input vec_t tv);
    bit ce, e_rv, e_fd;
    int k, e_id;
    logic [1:0] e_rdy;
    logic [3:0] e_idat, e_rd;
    rec_t nq[$];
    @(negedge clk);
    rst_n = r; en = e; hold = h; flush = f; req_valid = v; req_data = d;
    #1;
    ce = (m_state != 0) && !h;
    k = -1;
    if (m_state == 1 && ce && e && !f) begin
      for (int i = 0; i < NREQ; i++) begin
        int idx;
        idx = (m_ptr + i) % NREQ;
        if (k < 0 && v[idx]) k = idx;
      end
    end
    e_rdy  = (k >= 0) ? 2'(1 << k) : 2'b00;
    e_idat = (k >= 0) ? d[k*N +: N] : 4'h0;
    e_rv = 0; e_id = 0; e_rd = 0;
    foreach (recs[j]) begin
      if (recs[j].left == 0 && m_prev_ce) begin
        e_rv = 1; e_id = recs[j].id; e_rd = 4'(recs[j].data);
      end
    end
    e_fd = (m_state == 2) && (recs.size() == 0);
    if (mode == 1) begin
      e_rdy = tv.rdy; e_idat = tv.idat; e_rv = tv.rv; e_id = int'(tv.id);
      e_rd = tv.rd; e_fd = tv.fd;
      ce = tv.ce;
    end
    if (mode != 2) begin
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("dl_ce", 32'(dl_ce), 32'(ce));
      chk("dl_idata", 32'(dl_idata), 32'(e_idat));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_rv) begin
        chk("rsp_id", 32'(rsp_id), 32'(e_id));
        chk("rsp_data", 32'(rsp_data), 32'(e_rd));
      end
      chk("flush_done", 32'(flush_done), 32'(e_fd));
    end
    obs_rv = rsp_valid; obs_fd = flush_done; obs_rd = rsp_data;
    // recompute model ce (table mode may have overridden it)
    ce = (m_state != 0) && !h;
    @(posedge clk);
    cyc++;
    if (!r) begin
      recs.delete(); m_state = 0; m_ptr = 0; m_prev_ce = 0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    end else begin
      if (ce) begin
        foreach (recs[j]) if (recs[j].left > 0) nq.push_back('{recs[j].id, recs[j].data, recs[j].left - 1});
        if (k >= 0) begin
          nq.push_back('{k, int'(d[k*N +: N]), DELAY - 1});
          m_ptr = (k + 1) % NREQ;
          m_cnt[k]++;
        end
        recs = nq;
      end
      case (m_state)
        0: if (e) m_state = 1;
        1: if (f) m_state = 2; else if (!e) m_state = (e_fd_busy(recs.size(), ce, k)) ? 2 : 0;
        2: if (e_fd) m_state = 0;
        default: m_state = 0;
      endcase
      m_prev_ce = ce;
    end
  endtask

  // Pre-edge pipe occupancy, recovered from post-edge queue: busy before the
  // edge unless the queue is empty and held nothing in flight.
  bit pre_busy;
  function automatic bit e_fd_busy(input int unused_size, input bit unused_ce, input int unused_k);
    return pre_busy;
  endfunction

  task automatic go(input bit r, e, h, f, input logic [1:0] v, input logic [7:0] d);
    pre_busy = (recs.size() != 0);
    step(0, r, e, h, f, v, d, none_v);
  endtask

`ifdef DL_ARB_STATS_EN
  task automatic chk_stats();
    #1;
    for (int i = 0; i < NREQ; i++) chk("stat_grants", 32'(stat_grants[i*16 +: 16]), 32'(m_cnt[i]));
  endtask
`endif

  int rv_cnt, fd_cnt, first_rv, last_rv;
  logic [3:0] exp_d;

  initial begin
    none_v = '{0, 0, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0, 0, 4'h0, 0};
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    //            r  e  h  f  v      rdy    ce idat  rv id rd    fd
    tab[0]  = '{1'b0,1'b0,1'b0,1'b0,2'b11, 2'b00,1'b0,4'h0,1'b0,1'b0,4'h0,1'b0};
    tab[1]  = '{1'b0,1'b0,1'b0,1'b0,2'b11, 2'b00,1'b0,4'h0,1'b0,1'b0,4'h0,1'b0};
    tab[2]  = '{1'b1,1'b1,1'b0,1'b0,2'b11, 2'b00,1'b0,4'h0,1'b0,1'b0,4'h0,1'b0};
    tab[3]  = '{1'b1,1'b1,1'b0,1'b0,2'b11, 2'b01,1'b1,4'hA,1'b0,1'b0,4'h0,1'b0};
    tab[4]  = '{1'b1,1'b1,1'b0,1'b0,2'b11, 2'b10,1'b1,4'h5,1'b0,1'b0,4'h0,1'b0};
    tab[5]  = '{1'b1,1'b1,1'b0,1'b0,2'b11, 2'b01,1'b1,4'hA,1'b0,1'b0,4'h0,1'b0};
    tab[6]  = '{1'b1,1'b1,1'b0,1'b0,2'b11, 2'b10,1'b1,4'h5,1'b1,1'b0,4'hA,1'b0};
    tab[7]  = '{1'b1,1'b1,1'b0,1'b0,2'b00, 2'b00,1'b1,4'h0,1'b1,1'b1,4'h5,1'b0};
    tab[8]  = '{1'b1,1'b1,1'b0,1'b0,2'b00, 2'b00,1'b1,4'h0,1'b1,1'b0,4'hA,1'b0};
    tab[9]  = '{1'b1,1'b1,1'b0,1'b0,2'b00, 2'b00,1'b1,4'h0,1'b1,1'b1,4'h5,1'b0};
    tab[10] = '{1'b1,1'b1,1'b0,1'b0,2'b00, 2'b00,1'b1,4'h0,1'b0,1'b0,4'h0,1'b0};
    tab[11] = '{1'b1,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b1,4'h0,1'b0,1'b0,4'h0,1'b0};
    tab[12] = '{1'b1,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b0,4'h0,1'b0,1'b0,4'h0,1'b0};

    step(2, 0, 0, 0, 0, 2'b11, 8'h5A, none_v);
    for (int t = 0; t < 13; t++) begin
      pre_busy = (recs.size() != 0);
      step(1, tab[t].r, tab[t].e, tab[t].h, tab[t].f, tab[t].v, 8'h5A, tab[t]);
    end

    // single requester 1 streams 0..7 back-to-back
    rv_cnt = 0; first_rv = -1; last_rv = -1; exp_d = 0;
    go(1, 1, 0, 0, 2'b00, 8'h00);
    for (int i = 0; i < 16; i++) begin
      if (i < 8) go(1, 1, 0, 0, 2'b10, {4'(i), 4'h0});
      else       go(1, i < 14, 0, 0, 2'b00, 8'h00);
      if (obs_rv) begin
        chk("stream_data", 32'(obs_rd), 32'(exp_d));
        exp_d++; rv_cnt++;
        if (first_rv < 0) first_rv = i;
        last_rv = i;
      end
    end
    chk("stream_count", 32'(rv_cnt), 32'd8);
    chk("stream_no_bubble", 32'(last_rv - first_rv), 32'd7);

    // two in flight, then hold for two cycles
    rv_cnt = 0; first_rv = -1;
    go(1, 1, 0, 0, 2'b00, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      go(1, i < 10, (i == 3 || i == 4), 0, (i <= 4) ? 2'b01 : 2'b00, 8'h0A);
      if (obs_rv) begin
        rv_cnt++;
        if (first_rv < 0) first_rv = i;
      end
    end
    chk("hold_rsp_count", 32'(rv_cnt), 32'd2);
    chk("hold_first_rsp", 32'(first_rv), 32'd6);

    // flush with two in flight
    rv_cnt = 0; fd_cnt = 0;
    go(1, 1, 0, 0, 2'b00, 8'h00);
    go(1, 1, 0, 0, 2'b11, 8'h5A);
    go(1, 1, 0, 0, 2'b11, 8'h5A);
    go(1, 1, 0, 1, 2'b11, 8'h5A);
    for (int i = 0; i < 12; i++) begin
      go(1, 0, (i == 1), 0, 2'b11, 8'h5A);
      if (obs_rv) rv_cnt++;
      if (obs_fd) fd_cnt++;
    end
    chk("flush_rsp_count", 32'(rv_cnt), 32'd2);
    chk("flush_done_pulses", 32'(fd_cnt), 32'd1);
    chk("flush_back_idle", 32'(dl_ce), 32'd0);

    // flush with empty pipe
    go(1, 1, 0, 0, 2'b00, 8'h00);
    go(1, 1, 0, 1, 2'b00, 8'h00);
    go(1, 0, 0, 0, 2'b00, 8'h00);
    chk("flush_empty_done", 32'(obs_fd), 32'd1);
    go(1, 0, 0, 0, 2'b00, 8'h00);

    // reset mid-stream
    go(1, 1, 0, 0, 2'b00, 8'h00);
    for (int i = 0; i < 4; i++) go(1, 1, 0, 0, 2'b11, 8'h3C);
`ifdef DL_ARB_STATS_EN
    chk_stats();
`endif
    go(0, 1, 0, 0, 2'b11, 8'h3C);
    rv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      go(1, 0, 0, 0, 2'b00, 8'h00);
      if (obs_rv) rv_cnt++;
    end
    chk("reset_drops_rsp", 32'(rv_cnt), 32'd0);
`ifdef DL_ARB_STATS_EN
    chk_stats();
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit e, h, f, r;
      logic [1:0] v;
      r = ($urandom_range(0, 149) != 0);
      e = (m_state == 0) ? 1'b1 : ($urandom_range(0, 19) != 0);
      v = e ? 2'($urandom_range(0, 3)) : 2'b00;
      h = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 29) == 0);
      go(r, e, h, f, v, 8'($urandom));
    end
`ifdef DL_ARB_STATS_EN
    chk_stats();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
